// File: rtl/bk_csel_adder_pipe.sv
// bk_csel_adder_pipe: two-stage pipelined carry-select adder/subtractor.
//   Stage 1 splits the operands into SEG_W-bit segments. Each segment gets a
//   Brent-Kung prefix adder for sum0/c0, and a binary-to-excess-1 converter
//   (BEC) that derives sum1/c1 = sum0 + 1. Stage 2 ripples the select carry
//   through one mux per segment.
//   Flow control is a single-stall valid/ready pipeline. Stage 1 may still
//   fill while stage 2 holds a stalled result.
//   Optional build macro BKCSA_ZERO_FLAG_EN adds a registered 'zero' output
//   (sum == 0).
module bk_csel_adder_pipe #(
   parameter int WIDTH = 32,
   parameter int SEG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef BKCSA_ZERO_FLAG_EN
   output logic             zero,
`endif
   output logic             ovf
);

   localparam int NSEG = (WIDTH + SEG_W - 1) / SEG_W;

   // ---------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------
   logic s1_valid_q;
   logic out_valid_q;
   logic accept;
   logic advance;

   assign advance  = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || advance;
   assign accept   = in_valid && in_ready;

   // ---------------------------------------------------------------------
   // Stage 1: operand conditioning and per-segment speculative sums
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] b_eff;
   logic             c_first;
   logic [WIDTH-1:0] sum0_d, sum1_d;
   logic [NSEG-1:0]  c0_d, c1_d;

   assign b_eff   = sub ? ~b : b;
   assign c_first = sub | cin;          // subtract forces the +1 of two's complement

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      localparam int LO = k * SEG_W;
      localparam int SW = (k == NSEG - 1) ? (WIDTH - LO) : SEG_W;

      logic [SW-1:0] x, y, p, gg, pp, cv, s0, s1;
      logic          ci;
      logic          run;

      assign x  = a[LO +: SW];
      assign y  = b_eff[LO +: SW];
      // Only segment 0 sees the real carry-in; the others assume 0 and let
      // stage 2 pick the +1 variant when needed.
      assign ci = (k == 0) ? c_first : 1'b0;

      // Brent-Kung prefix: up-sweep builds power-of-two groups, down-sweep
      // fills the remaining prefixes; gg[i] ends as the carry out of bit i.
      always_comb begin
         // NOTE: every variable gets a full default first, so no latch is inferred.
         p     = x ^ y;
         gg    = x & y;
         pp    = p;
         gg[0] = gg[0] | (pp[0] & ci);
         for (int d = 1; d < SW; d = d * 2) begin
            for (int i = 2 * d - 1; i < SW; i = i + 2 * d) begin
               gg[i] = gg[i] | (pp[i] & gg[i-d]);
               pp[i] = pp[i] & pp[i-d];
            end
         end
         for (int d = 4; d >= 1; d = d / 2) begin
            if (2 * d < SW) begin
               for (int i = 3 * d - 1; i < SW; i = i + 2 * d) begin
                  gg[i] = gg[i] | (pp[i] & gg[i-d]);
                  pp[i] = pp[i] & pp[i-d];
               end
            end
         end
         cv    = '0;
         cv[0] = ci;
         for (int i = 1; i < SW; i++) begin
            cv[i] = gg[i-1];
         end
         s0 = p ^ cv;
      end

      // BEC: sum0 + 1 by toggling each bit whose lower bits are all ones.
      always_comb begin
         s1  = '0;
         run = 1'b1;
         for (int i = 0; i < SW; i++) begin
            s1[i] = s0[i] ^ run;
            run   = run & s0[i];
         end
      end

      assign sum0_d[LO +: SW] = s0;
      assign sum1_d[LO +: SW] = s1;
      assign c0_d[k]          = gg[SW-1];
      assign c1_d[k]          = gg[SW-1] | run;
   end

   logic [WIDTH-1:0] sum0_q, sum1_q;
   logic [NSEG-1:0]  c0_q, c1_q;
   logic             a_msb_q, b_msb_q;

   // Stage-1 valid: updates whenever stage 1 is free to take new data
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         s1_valid_q <= 1'b0;
      end else if (in_ready) begin
         s1_valid_q <= accept;
      end
   end

   // Stage-1 datapath capture on accept
   always_ff @(posedge clk) begin
      // NOTE: no reset on the data registers; s1_valid_q alone says whether they hold anything.
      if (accept) begin
         sum0_q  <= sum0_d;
         sum1_q  <= sum1_d;
         c0_q    <= c0_d;
         c1_q    <= c1_d;
         a_msb_q <= a[WIDTH-1];
         b_msb_q <= b_eff[WIDTH-1];
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: carry-select ripple and result assembly
   // ---------------------------------------------------------------------
   logic [NSEG:0]    sel_c;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             ovf_d;

   // Select-carry ripple. sel_c[0] is 0 because segment 0 already holds its
   // true sum, so its mux resolves to sum0.
   always_comb begin
      sel_c = '0;
      for (int k = 1; k <= NSEG; k++) begin
         sel_c[k] = sel_c[k-1] ? c1_q[k-1] : c0_q[k-1];
      end
   end

   for (genvar k = 0; k < NSEG; k++) begin : g_sel
      localparam int LO = k * SEG_W;
      localparam int SW = (k == NSEG - 1) ? (WIDTH - LO) : SEG_W;
      assign sum_d[LO +: SW] = sel_c[k] ? sum1_q[LO +: SW] : sum0_q[LO +: SW];
   end

   assign cout_d = sel_c[NSEG];
   assign ovf_d  = (a_msb_q == b_msb_q) && (sum_d[WIDTH-1] != a_msb_q);

   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   // Output stage: loads on advance, keeps the last result across bubbles
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (advance) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

`ifdef BKCSA_ZERO_FLAG_EN
   logic zero_q;

   // Zero flag: registered alongside sum with identical hold behaviour
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q <= 1'b0;
      end else if (advance && s1_valid_q) begin
         zero_q <= (sum_d == '0);
      end
   end

   assign zero = zero_q;
`endif

endmodule
